// File: rtl/rgb565_pixel_assembler_pkg.sv
// Shared types and geometry helpers for the RGB565 frame load and scan paths.
package rgb565_pixel_assembler_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_FIRST  = 2'd1,
        WAIT_SECOND = 2'd2
    } asm_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Counter widths never collapse to zero bits, even for a degenerate dimension.
    function automatic int unsigned col_w(input int unsigned pixel_width);
        return (pixel_width > 1) ? $clog2(pixel_width) : 1;
    endfunction

    function automatic int unsigned row_w(input int unsigned pixel_height);
        return (pixel_height > 1) ? $clog2(pixel_height) : 1;
    endfunction

endpackage

// File: rtl/rgb565_pixel_assembler_if.sv
// Byte-in / pixel-write-out bundle between the host receiver, the assembler and the framebuffer.
interface rgb565_pixel_assembler_if
    import rgb565_pixel_assembler_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
);
    logic              frame_start;
    logic [7:0]        data_in;
    logic              data_valid;
    rgb565_t           pixel_data;
    logic [ADDR_W-1:0] pixel_addr;
    logic              pixel_we;
    logic              frame_done;
    logic              byte_error;
    logic              busy;

    modport master (
        output frame_start, data_in, data_valid,
        input  pixel_data, pixel_addr, pixel_we, frame_done, byte_error, busy
    );

    modport slave (
        input  frame_start, data_in, data_valid,
        output pixel_data, pixel_addr, pixel_we, frame_done, byte_error, busy
    );
endinterface

// File: rtl/rgb565_pixel_assembler_frame_address_counter.sv
// Raster-order column/row counter; column wraps into a row increment.
module rgb565_pixel_assembler_frame_address_counter
    import rgb565_pixel_assembler_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = 64,
    parameter int unsigned PIXEL_HEIGHT = 32,
    localparam int unsigned COL_W = col_w(PIXEL_WIDTH),
    localparam int unsigned ROW_W = row_w(PIXEL_HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_pixel_c
);
    logic col_last_c;

    assign col_last_c   = (col == COL_W'(PIXEL_WIDTH - 1));
    assign last_pixel_c = col_last_c && (row == ROW_W'(PIXEL_HEIGHT - 1));

    // clear has priority so a restart on the same cycle as a write lands on address 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_last_c) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end
endmodule

// File: rtl/rgb565_pixel_assembler.sv
// Pairs received bytes into RGB565 pixels and issues raster-ordered framebuffer writes.
module rgb565_pixel_assembler
    import rgb565_pixel_assembler_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH    = 64,
    parameter int unsigned PIXEL_HEIGHT   = 32,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                    clk,
    input logic                    reset,
    rgb565_pixel_assembler_if.slave bus
);
    localparam int unsigned COL_W   = col_w(PIXEL_WIDTH);
    localparam int unsigned ROW_W   = row_w(PIXEL_HEIGHT);
    localparam int unsigned ADDR_W  = ROW_W + COL_W;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

    asm_state_e         state_q, state_d;
    logic [7:0]         first_q;
    logic [TIMER_W-1:0] timer_q;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               last_pixel_c;
    logic               timer_expired_c;

    logic               cnt_clear, cnt_advance, latch_first, timer_run;
    logic               pixel_we_d, frame_done_d, byte_error_d;
    logic [15:0]        pixel_data_d, pixel_data_q;
    logic [ADDR_W-1:0]  pixel_addr_d, pixel_addr_q;
    logic               pixel_we_q, frame_done_q, byte_error_q, busy_q;

    rgb565_pixel_assembler_frame_address_counter #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .PIXEL_HEIGHT(PIXEL_HEIGHT)
    ) u_addr (
        .clk         (clk),
        .reset       (reset),
        .clear       (cnt_clear),
        .advance     (cnt_advance),
        .col         (col),
        .row         (row),
        .last_pixel_c(last_pixel_c)
    );

    assign timer_expired_c = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: frame_start beats data_valid, a byte beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.frame_start) state_d = WAIT_FIRST;
            end
            WAIT_FIRST: begin
                if (bus.frame_start)     state_d = WAIT_FIRST;
                else if (bus.data_valid) state_d = WAIT_SECOND;
            end
            WAIT_SECOND: begin
                if (bus.frame_start)     state_d = WAIT_FIRST;
                else if (bus.data_valid) state_d = last_pixel_c ? IDLE : WAIT_FIRST;
                else if (timer_expired_c) state_d = WAIT_FIRST;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-cycle actions and next values of the registered outputs
    always_comb begin
        cnt_clear    = 1'b0;
        cnt_advance  = 1'b0;
        latch_first  = 1'b0;
        timer_run    = 1'b0;
        pixel_we_d   = 1'b0;
        frame_done_d = 1'b0;
        byte_error_d = 1'b0;
        pixel_data_d = pixel_data_q;
        pixel_addr_d = pixel_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.frame_start)     cnt_clear    = 1'b1;
                else if (bus.data_valid) byte_error_d = 1'b1;
            end
            WAIT_FIRST: begin
                if (bus.frame_start)     cnt_clear   = 1'b1;
                else if (bus.data_valid) latch_first = 1'b1;
            end
            WAIT_SECOND: begin
                if (bus.frame_start) begin
                    cnt_clear = 1'b1;
                end else if (bus.data_valid) begin
                    pixel_we_d   = 1'b1;
                    pixel_data_d = MSB_FIRST ? {first_q, bus.data_in} : {bus.data_in, first_q};
                    pixel_addr_d = {row, col};
                    frame_done_d = last_pixel_c;
                    cnt_clear    = last_pixel_c;
                    cnt_advance  = !last_pixel_c;
                end else if (timer_expired_c) begin
                    byte_error_d = 1'b1;
                end else begin
                    timer_run = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= '0;
            timer_q <= '0;
        end else begin
            if (latch_first) begin
                first_q <= bus.data_in;
                timer_q <= '0;
            end else if (timer_run && (timer_q != '1)) begin
                timer_q <= timer_q + TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_data_q <= '0;
            pixel_addr_q <= '0;
            pixel_we_q   <= 1'b0;
            frame_done_q <= 1'b0;
            byte_error_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pixel_data_q <= pixel_data_d;
            pixel_addr_q <= pixel_addr_d;
            pixel_we_q   <= pixel_we_d;
            frame_done_q <= frame_done_d;
            byte_error_q <= byte_error_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.pixel_data = rgb565_t'(pixel_data_q);
    assign bus.pixel_addr = pixel_addr_q;
    assign bus.pixel_we   = pixel_we_q;
    assign bus.frame_done = frame_done_q;
    assign bus.byte_error = byte_error_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_rgb565_pixel_assembler.sv
// Scoreboard bench for rgb565_pixel_assembler: expected writes/errors queued by stimulus, popped by a monitor.
module tb_rgb565_pixel_assembler;
    localparam int unsigned W  = 64;
    localparam int unsigned H  = 32;
    localparam int unsigned AW = 11;

    typedef struct {
        logic [15:0]   data;
        logic [AW-1:0] addr;
        logic          done;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rgb565_pixel_assembler_if #(.ADDR_W(AW)) bus ();
    rgb565_pixel_assembler_if #(.ADDR_W(AW)) bus2 ();

    rgb565_pixel_assembler #(
        .PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    rgb565_pixel_assembler #(
        .PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(1024)
    ) dut_lsb (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    logic [15:0] px, px2;
    assign px  = bus.pixel_data;
    assign px2 = bus2.pixel_data;

    wr_t exp_wr[$];
    bit  exp_err_q[$];
    wr_t mon_e;
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write or error the DUT presents must match the next queued expectation
    always @(negedge clk) begin
        if (bus.pixel_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 32'(bus.pixel_we), 32'd0);
            end else begin
                mon_e = exp_wr.pop_front();
                check("pixel_data", 32'(px), 32'(mon_e.data));
                check("pixel_addr", 32'(bus.pixel_addr), 32'(mon_e.addr));
                check("frame_done", 32'(bus.frame_done), 32'(mon_e.done));
            end
        end else if (bus.frame_done) begin
            check("frame_done_without_we", 32'(bus.frame_done), 32'd0);
        end
        if (bus.byte_error) begin
            if (exp_err_q.size() == 0) check("unexpected_byte_error", 32'(bus.byte_error), 32'd0);
            else void'(exp_err_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic fs, input logic dv, input logic [7:0] b);
        bus.frame_start = fs;
        bus.data_valid  = dv;
        bus.data_in     = b;
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.data_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_wr(input logic [15:0] d, input int unsigned a, input logic done);
        wr_t e;
        e.data = d;
        e.addr = AW'(a);
        e.done = done;
        exp_wr.push_back(e);
    endtask

    task automatic pixel(input logic [15:0] d, input int unsigned a, input logic done);
        push_wr(d, a, done);
        drive(1'b0, 1'b1, d[15:8]);
        drive(1'b0, 1'b1, d[7:0]);
    endtask

    task automatic drain(input string name);
        idle(3);
        check({name, "_writes_pending"}, 32'(exp_wr.size()), 32'd0);
        check({name, "_errors_pending"}, 32'(exp_err_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.frame_start  = 1'b0; bus.data_valid  = 1'b0; bus.data_in  = 8'h00;
        bus2.frame_start = 1'b0; bus2.data_valid = 1'b0; bus2.data_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_pixel_data", 32'(px), 32'd0);
        check("rst_pixel_addr", 32'(bus.pixel_addr), 32'd0);
        check("rst_pixel_we", 32'(bus.pixel_we), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_byte_error", 32'(bus.byte_error), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Byte while idle: error pulse only
        exp_err_q.push_back(1'b1);
        drive(1'b0, 1'b1, 8'h5C);
        idle(2);
        check("idle_busy", 32'(bus.busy), 32'd0);
        drain("idle_byte");

        // First pixel and its one-cycle latency
        drive(1'b1, 1'b0, 8'h00);
        check("armed_busy", 32'(bus.busy), 32'd1);
        push_wr(16'hF800, 0, 1'b0);
        drive(1'b0, 1'b1, 8'hF8);
        drive(1'b0, 1'b1, 8'h00);
        check("we_latency", 32'(bus.pixel_we), 32'd1);
        idle(1);
        check("we_single_cycle", 32'(bus.pixel_we), 32'd0);
        check("data_hold", 32'(px), 32'hF800);

        // Timeout: error exactly 1024 idle cycles after the lone byte
        exp_err_q.push_back(1'b1);
        drive(1'b0, 1'b1, 8'h12);
        idle(1023);
        #1;
        check("timeout_not_early", 32'(exp_err_q.size()), 32'd1);
        idle(1);
        #1;
        check("timeout_fired", 32'(exp_err_q.size()), 32'd0);
        pixel(16'hABCD, 1, 1'b0);

        // Byte on the deadline cycle wins over the timeout
        push_wr(16'h3456, 2, 1'b0);
        drive(1'b0, 1'b1, 8'h34);
        idle(1023);
        drive(1'b0, 1'b1, 8'h56);
        drain("deadline");

        // Restart mid-frame with a coincident byte
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) pixel(16'h1000 + 16'(i), 32'(i), 1'b0);
        drive(1'b0, 1'b1, 8'h77);
        drive(1'b1, 1'b1, 8'h99);
        pixel(16'h5AA5, 0, 1'b0);
        drain("restart");

        // Full frame, value = index
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < int'(W * H); i++) pixel(16'(i), 32'(i), (i == int'(W * H) - 1));
        check("last_done", 32'(bus.frame_done), 32'd1);
        check("last_busy", 32'(bus.busy), 32'd0);
        drain("full_frame");
        check("after_frame_done", 32'(bus.frame_done), 32'd0);

        // Reset between the two bytes of pixel 5
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) pixel(16'h2000 + 16'(i), 32'(i), 1'b0);
        drive(1'b0, 1'b1, 8'h42);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_pixel_data", 32'(px), 32'd0);
        check("mid_rst_pixel_addr", 32'(bus.pixel_addr), 32'd0);
        check("mid_rst_pixel_we", 32'(bus.pixel_we), 32'd0);
        check("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("mid_rst_byte_error", 32'(bus.byte_error), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_err_q.push_back(1'b1);
        exp_err_q.push_back(1'b1);
        drive(1'b0, 1'b1, 8'h11);
        drive(1'b0, 1'b1, 8'h22);
        drain("post_reset");
        check("post_reset_busy", 32'(bus.busy), 32'd0);

        // LSB-first instance
        bus2.frame_start = 1'b1;
        @(negedge clk);
        bus2.frame_start = 1'b0;
        bus2.data_valid  = 1'b1;
        bus2.data_in     = 8'h00;
        @(negedge clk);
        bus2.data_in = 8'hF8;
        @(negedge clk);
        bus2.data_in = 8'h34;
        check("lsb_we", 32'(bus2.pixel_we), 32'd1);
        check("lsb_data", 32'(px2), 32'hF800);
        check("lsb_addr", 32'(bus2.pixel_addr), 32'd0);
        @(negedge clk);
        bus2.data_in = 8'h12;
        @(negedge clk);
        bus2.data_valid = 1'b0;
        check("lsb_data2", 32'(px2), 32'h1234);
        check("lsb_addr2", 32'(bus2.pixel_addr), 32'd1);

        drain("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
